// File: rtl/mii_rx_pkg.sv
// Shared state encoding and nibble constants for the MII receive path.
// Also decoded by sinhr_input_data on its state_in port.
package mii_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALIGN    = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    DROP     = 3'd4
  } rx_state_t;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth register delay for a small control bus.
// Clears to zero on reset.
module sig_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/mii_rx_frame_ctrl.sv
// MII receive frame sequencer: alignment window, preamble/SFD check,
// low-nibble-first byte assembly, frame length and error flags.
module mii_rx_frame_ctrl
  import mii_rx_pkg::*;
#(
  parameter int ALIGN_CYCLES = 4,
  parameter int PIPE_DLY     = 2,
  parameter int MIN_PRE_NIB  = 6,
  parameter int MAX_PRE_NIB  = 16,
  parameter int MAX_BYTES    = 1522
) (
  input  logic        clk_25Mz,
  input  logic        reset_n,
  input  logic        CRS,
  input  logic        RX_DV,
  input  logic [3:0]  data_sinhr_in,
  output logic [2:0]  state_out,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [15:0] rx_len,
  output logic        err_preamble,
  output logic        err_odd,
  output logic        err_long,
  output logic        busy
);

  localparam int AW = $clog2(ALIGN_CYCLES + 1);
  localparam int PW = $clog2(MAX_PRE_NIB + 1);

  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MIN    = PW'(MIN_PRE_NIB);
  localparam logic [PW-1:0] PRE_LAST   = PW'(MAX_PRE_NIB - 1);
  localparam logic [15:0]   LEN_MAX    = 16'(MAX_BYTES);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Assert immediately, release on a clock edge.
  always_ff @(posedge clk_25Mz or negedge reset_n) begin
    if (!reset_n)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [1:0] line_d;
  logic       crs_d;
  logic       dv_d;

  sig_delay_line #(
    .WIDTH (2),
    .DEPTH (PIPE_DLY)
  ) u_dly (
    .clk   (clk_25Mz),
    .rst_n (rst_n),
    .d     ({CRS, RX_DV}),
    .q     (line_d)
  );

  assign {crs_d, dv_d} = line_d;

  rx_state_t     state;
  logic [AW-1:0] align_cnt;
  logic [PW-1:0] pre_cnt;
  logic          phase;
  logic [3:0]    low_nib;

  logic is_pre;
  logic is_sfd;

  assign is_pre = (data_sinhr_in == PRE_NIB);
  assign is_sfd = (data_sinhr_in == SFD_NIB);

  always_ff @(posedge clk_25Mz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      align_cnt     <= '0;
      pre_cnt       <= '0;
      phase         <= 1'b0;
      low_nib       <= 4'h0;
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_len        <= 16'h0000;
      err_preamble  <= 1'b0;
      err_odd       <= 1'b0;
      err_long      <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      err_odd       <= 1'b0;

      unique case (state)
        IDLE: begin
          if (dv_d && crs_d) begin
            state        <= ALIGN;
            err_preamble <= 1'b0;
            err_long     <= 1'b0;
            rx_len       <= 16'h0000;
            align_cnt    <= '0;
            pre_cnt      <= '0;
            phase        <= 1'b0;
          end
        end

        ALIGN: begin
          if (!dv_d)
            state <= IDLE;
          else if (align_cnt == ALIGN_LAST)
            state <= PREAMBLE;
          else
            align_cnt <= align_cnt + 1'b1;
        end

        PREAMBLE: begin
          unique case (1'b1)
            !dv_d: begin
              state        <= IDLE;
              err_preamble <= 1'b1;
            end
            is_pre: begin
              pre_cnt <= pre_cnt + 1'b1;
              if (pre_cnt == PRE_LAST) begin
                state        <= DROP;
                err_preamble <= 1'b1;
              end
            end
            is_sfd && (pre_cnt >= PRE_MIN):
              state <= DATA;
            default: begin
              state        <= DROP;
              err_preamble <= 1'b1;
            end
          endcase
        end

        DATA: begin
          if (!dv_d) begin
            state   <= IDLE;
            rx_eof  <= 1'b1;
            err_odd <= phase;
          end else if (!phase) begin
            low_nib <= data_sinhr_in;
            phase   <= 1'b1;
          end else if (rx_len >= LEN_MAX) begin
            // Byte that would overrun the limit is swallowed.
            state    <= DROP;
            err_long <= 1'b1;
          end else begin
            rx_byte       <= {data_sinhr_in, low_nib};
            rx_byte_valid <= 1'b1;
            rx_sof        <= (rx_len == 16'h0000);
            rx_len        <= sat_inc16(rx_len);
            phase         <= 1'b0;
          end
        end

        DROP: begin
          if (!dv_d && !crs_d)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign state_out = state;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mii_rx_frame_ctrl.sv
// Randomized frame bench for mii_rx_frame_ctrl with a frame-level
// reference model (expected bytes, eofs and sticky flags per frame).
module tb_mii_rx_frame_ctrl;

  localparam int ALIGN_CYCLES = 4;
  localparam int PIPE_DLY     = 2;
  localparam int MIN_PRE_NIB  = 6;
  localparam int MAX_PRE_NIB  = 16;
  localparam int MAX_BYTES    = 1522;
  localparam int LEAD         = ALIGN_CYCLES + 1;

  logic        clk_25Mz;
  logic        reset_n;
  logic        CRS;
  logic        RX_DV;
  logic [3:0]  data_sinhr_in;
  logic [2:0]  state_out;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [15:0] rx_len;
  logic        err_preamble;
  logic        err_odd;
  logic        err_long;
  logic        busy;

  mii_rx_frame_ctrl #(
    .ALIGN_CYCLES (ALIGN_CYCLES),
    .PIPE_DLY     (PIPE_DLY),
    .MIN_PRE_NIB  (MIN_PRE_NIB),
    .MAX_PRE_NIB  (MAX_PRE_NIB),
    .MAX_BYTES    (MAX_BYTES)
  ) dut (
    .clk_25Mz      (clk_25Mz),
    .reset_n       (reset_n),
    .CRS           (CRS),
    .RX_DV         (RX_DV),
    .data_sinhr_in (data_sinhr_in),
    .state_out     (state_out),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .rx_len        (rx_len),
    .err_preamble  (err_preamble),
    .err_odd       (err_odd),
    .err_long      (err_long),
    .busy          (busy)
  );

  initial clk_25Mz = 1'b0;
  always #20 clk_25Mz = ~clk_25Mz;

  int n_chk = 0;
  int n_err = 0;

  bit         dv_q[$];
  bit         crs_q[$];
  logic [3:0] nib_q[$];

  logic [7:0] exp_b[$];
  bit         exp_sof[$];
  int         exp_len[$];
  bit         exp_odd[$];
  bit         exp_epre;
  bit         exp_elong;
  int         exp_rxlen;
  bit         exp_drop;
  bit         exp_data;

  logic [7:0] got_b[$];
  bit         got_sof[$];
  int         got_len[$];
  bit         got_odd[$];
  int         stray;
  logic [7:0] seen_st;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_nib(input logic [3:0] n);
    dv_q.push_back(1'b1);
    crs_q.push_back(1'b1);
    nib_q.push_back(n);
  endtask

  // Append one frame to the stimulus and its outcome to the model.
  task automatic add_frame(input int npre, input int nbytes,
                           input bit odd, input int gap,
                           input bit incr);
    bit         ok_pre;
    logic [7:0] b;
    int         k;
    ok_pre = (npre >= MIN_PRE_NIB) && (npre < MAX_PRE_NIB);
    for (int i = 0; i < LEAD; i++)
      push_nib(4'($urandom));
    for (int i = 0; i < npre; i++)
      push_nib(4'h5);
    push_nib(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      push_nib(b[3:0]);
      push_nib(b[7:4]);
      if (ok_pre && i < MAX_BYTES) begin
        exp_b.push_back(b);
        exp_sof.push_back(i == 0);
      end
    end
    if (odd)
      push_nib(4'($urandom));
    k = $urandom_range(0, 3);
    for (int j = 0; j < k; j++)
      crs_q[crs_q.size() - 1 - j] = 1'b0;
    for (int i = 0; i < gap; i++) begin
      dv_q.push_back(1'b0);
      crs_q.push_back(1'b0);
      nib_q.push_back(4'h0);
    end
    if (!ok_pre) begin
      exp_epre  = 1'b1;
      exp_elong = 1'b0;
      exp_rxlen = 0;
      exp_drop  = 1'b1;
    end else if (nbytes > MAX_BYTES) begin
      exp_epre  = 1'b0;
      exp_elong = 1'b1;
      exp_rxlen = MAX_BYTES;
      exp_drop  = 1'b1;
      exp_data  = 1'b1;
    end else begin
      exp_epre  = 1'b0;
      exp_elong = 1'b0;
      exp_rxlen = nbytes;
      exp_data  = 1'b1;
      exp_len.push_back(nbytes);
      exp_odd.push_back(odd);
    end
  endtask

  task automatic sample();
    if (rx_byte_valid) begin
      got_b.push_back(rx_byte);
      got_sof.push_back(rx_sof);
    end
    if (rx_eof) begin
      got_len.push_back(int'(rx_len));
      got_odd.push_back(err_odd);
    end
    if ((rx_sof && !rx_byte_valid) || (err_odd && !rx_eof) ||
        (busy != (state_out != 3'd0)))
      stray++;
    seen_st[state_out] = 1'b1;
  endtask

  task automatic step(input int t);
    @(negedge clk_25Mz);
    sample();
    RX_DV = (t < dv_q.size()) ? dv_q[t] : 1'b0;
    CRS   = (t < crs_q.size()) ? crs_q[t] : 1'b0;
    data_sinhr_in = (t >= PIPE_DLY && t - PIPE_DLY < nib_q.size()) ?
                    nib_q[t - PIPE_DLY] : 4'h0;
  endtask

  task automatic clear_all();
    dv_q.delete();  crs_q.delete();  nib_q.delete();
    exp_b.delete(); exp_sof.delete();
    exp_len.delete(); exp_odd.delete();
    got_b.delete(); got_sof.delete();
    got_len.delete(); got_odd.delete();
    stray = 0;
    seen_st = 8'h00;
    exp_drop = 1'b0;
    exp_data = 1'b0;
  endtask

  task automatic run_check(input string tag);
    int         total;
    int         nb;
    int         ne;
    logic [7:0] st;
    total = dv_q.size() + PIPE_DLY + 8;
    for (int t = 0; t < total; t++)
      step(t);
    @(negedge clk_25Mz);
    sample();
    chk({tag, ".nbytes"}, got_b.size(), exp_b.size());
    nb = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s.byte%0d", tag, i), got_b[i], exp_b[i]);
      chk($sformatf("%s.sof%0d", tag, i), got_sof[i], exp_sof[i]);
    end
    chk({tag, ".neof"}, got_len.size(), exp_len.size());
    ne = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
    for (int i = 0; i < ne; i++) begin
      chk($sformatf("%s.eoflen%0d", tag, i), got_len[i], exp_len[i]);
      chk($sformatf("%s.odd%0d", tag, i), got_odd[i], exp_odd[i]);
    end
    st = 8'h07 | (exp_data ? 8'h08 : 8'h00) | (exp_drop ? 8'h10 : 8'h00);
    chk({tag, ".states"}, seen_st, st);
    chk({tag, ".stray"}, stray, 0);
    chk({tag, ".err_pre"}, err_preamble, exp_epre);
    chk({tag, ".err_long"}, err_long, exp_elong);
    chk({tag, ".rx_len"}, rx_len, exp_rxlen);
    chk({tag, ".idle"}, state_out, 0);
    chk({tag, ".busy"}, busy, 0);
    clear_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, rx_byte_valid, 0);
    chk({tag, ".byte"}, rx_byte, 0);
    chk({tag, ".sof"}, rx_sof, 0);
    chk({tag, ".eof"}, rx_eof, 0);
    chk({tag, ".len"}, rx_len, 0);
    chk({tag, ".epre"}, err_preamble, 0);
    chk({tag, ".eodd"}, err_odd, 0);
    chk({tag, ".elong"}, err_long, 0);
    chk({tag, ".state"}, state_out, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    int nf;
    int total;
    reset_n = 1'b0;
    RX_DV = 1'b0;
    CRS = 1'b0;
    data_sinhr_in = 4'h0;
    clear_all();
    repeat (3) @(negedge clk_25Mz);
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk_25Mz);

    add_frame(7, 64, 1'b0, 4, 1'b1);
    run_check("good64");
    add_frame(4, 10, 1'b0, 4, 1'b1);
    run_check("shortpre");
    add_frame(7, 10, 1'b1, 4, 1'b1);
    run_check("odd");
    add_frame(MIN_PRE_NIB, 3, 1'b0, 3, 1'b0);
    run_check("premin");
    add_frame(MIN_PRE_NIB - 1, 3, 1'b0, 3, 1'b0);
    run_check("premin_m1");
    add_frame(MAX_PRE_NIB - 1, 3, 1'b0, 3, 1'b0);
    run_check("premax_m1");
    add_frame(MAX_PRE_NIB, 3, 1'b0, 3, 1'b0);
    run_check("premax");
    add_frame(7, MAX_BYTES, 1'b0, 4, 1'b0);
    run_check("maxlen");
    add_frame(7, MAX_BYTES + 1, 1'b0, 4, 1'b1);
    run_check("toolong");

    // Reset in the middle of the data phase.
    add_frame(8, 40, 1'b0, 0, 1'b1);
    total = LEAD + 8 + 1 + 2 * 21 + PIPE_DLY + 2;
    for (int t = 0; t < total; t++)
      step(t);
    @(negedge clk_25Mz);
    sample();
    chk("midrst.nbytes_ge20", got_b.size() >= 20, 1);
    for (int i = 0; i < 20 && i < got_b.size(); i++)
      chk($sformatf("midrst.byte%0d", i), got_b[i], exp_b[i]);
    reset_n = 1'b0;
    RX_DV = 1'b0;
    CRS = 1'b0;
    #1;
    chk_zero("midrst");
    clear_all();
    repeat (3) @(negedge clk_25Mz);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_25Mz);
    add_frame(7, 12, 1'b0, 4, 1'b0);
    run_check("afterrst");

    add_frame(7, 16, 1'b0, 1, 1'b0);
    add_frame(7, 16, 1'b0, 4, 1'b0);
    run_check("b2b");

    for (int r = 0; r < 12; r++) begin
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++)
        add_frame($urandom_range(3, 17), $urandom_range(0, 40),
                  1'($urandom), $urandom_range(1, 4), 1'b0);
      run_check($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
